// File: rtl/dm_pkg.sv
// Shared defaults and clear-controller state encoding for the line data memory.
package dm_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int WORDS_DEF  = 16;
    localparam int AW_DEF     = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/dm_clear_fsm.sv
// Zero-fill sweep controller: walks every line address once, one line per cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal operation, memory open to reads and writes
// ST_CLEAR | writing zero to line cnt_q; reads, writes and restarts ignored
module dm_clear_fsm
    import dm_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_start,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] CNT_LAST = '1;

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Terminal count is tested before incrementing, so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_CLEAR);
        clr_we   = (state_q == ST_CLEAR) && !rst;
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/line_data_mem.sv
// Line-wide storage with per-word write mask, registered write-first read port
// and a zero-fill sweep that takes the memory offline while it runs.
module line_data_mem
    import dm_pkg::*;
#(
    parameter  int WORD_W = WORD_W_DEF,
    parameter  int WORDS  = WORDS_DEF,
    parameter  int AW     = AW_DEF,
    localparam int LINE_W = WORD_W * WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORDS-1:0]  wr_mask,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [LINE_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr_start,
    output logic              busy
);

    localparam int DEPTH = 2 ** AW;

    logic [LINE_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [AW-1:0]     clr_addr;
    logic              wr_accept;
    logic              rd_accept;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] rd_line;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    dm_clear_fsm #(
        .AW (AW)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign wr_accept = wr_en && !busy && !rst;
    assign rd_accept = rd_en && !busy && !rst;

    // Merged line: masked words from wr_data, the rest from the stored line.
    always_comb begin
        wr_line = mem[wr_addr];
        for (int i = 0; i < WORDS; i++) begin
            if (wr_mask[i]) begin
                wr_line[i*WORD_W +: WORD_W] = wr_data[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_line;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Write-first: a same-address read sees the merged line being written.
    always_comb begin
        if (wr_accept && (wr_addr == rd_addr)) begin
            rd_line = wr_line;
        end else begin
            rd_line = mem[rd_addr];
        end
        rd_data_d  = rd_accept ? rd_line : rd_data_q;
        rd_valid_d = rd_accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_line_data_mem.sv
// Scoreboard bench for line_data_mem with a 16-line memory.
module tb_line_data_mem;

    localparam int WORD_W = 16;
    localparam int WORDS  = 16;
    localparam int AW     = 4;
    localparam int LINE_W = WORD_W * WORDS;
    localparam int DEPTH  = 2 ** AW;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WORDS-1:0]  wr_mask;
    logic [LINE_W-1:0] wr_data;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [LINE_W-1:0] rd_data;
    logic              rd_valid;
    logic              clr_start;
    logic              busy;

    line_data_mem #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS),
        .AW     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .clr_start (clr_start),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt = 0;

    logic [LINE_W-1:0] m_mem [DEPTH];
    logic [LINE_W-1:0] exp_q [$];
    logic [LINE_W-1:0] m_rd_data;
    logic              m_valid;
    logic              m_busy;
    logic [AW-1:0]     m_sweep;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] fill(input logic [15:0] base, input logic [15:0] inc);
        logic [LINE_W-1:0] l;
        logic [15:0] w;
        w = base;
        for (int i = 0; i < WORDS; i++) begin
            l[i*WORD_W +: WORD_W] = w;
            w = w + inc;
        end
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) begin
            l[i*32 +: 32] = $urandom | 32'h0000_0001;
        end
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] old_l, input logic [LINE_W-1:0] new_l,
                                                input logic [WORDS-1:0] m);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < WORDS; i++) begin
            l[i*WORD_W +: WORD_W] = m[i] ? new_l[i*WORD_W +: WORD_W] : old_l[i*WORD_W +: WORD_W];
        end
        return l;
    endfunction

    // One clock: drive inputs, advance the model at the edge, check just after it.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [WORDS-1:0] wm,
                        input logic [LINE_W-1:0] wd, input logic re, input logic [AW-1:0] ra,
                        input logic cs, input logic r);
        logic [LINE_W-1:0] line;
        wr_en = we; wr_addr = wa; wr_mask = wm; wr_data = wd;
        rd_en = re; rd_addr = ra; clr_start = cs; rst = r;
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0; m_sweep = '0; m_valid = 1'b0; m_rd_data = '0;
        end else if (m_busy) begin
            m_valid = 1'b0;
            m_mem[m_sweep] = '0;
            if (m_sweep == AW'(DEPTH - 1)) begin
                m_busy = 1'b0;
                m_sweep = '0;
            end else begin
                m_sweep = m_sweep + AW'(1);
            end
        end else begin
            m_valid = re;
            if (re) begin
                line = (we && wa == ra) ? merge(m_mem[wa], wd, wm) : m_mem[ra];
                exp_q.push_back(line);
                m_rd_data = line;
            end
            if (we) m_mem[wa] = merge(m_mem[wa], wd, wm);
            if (cs) begin
                m_busy = 1'b1;
                m_sweep = '0;
            end
        end
        #1;
        if (busy === 1'b1) busy_cnt++;
        check("rd_valid", LINE_W'(rd_valid), LINE_W'(m_valid));
        check("busy", LINE_W'(busy), LINE_W'(m_busy));
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) check("rd_spurious", LINE_W'(rd_valid), '0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end else begin
            check("rd_hold", rd_data, m_rd_data);
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WORDS-1:0] m, input logic [LINE_W-1:0] d);
        step(1'b1, a, m, d, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, '0, '0, '0, 1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic fill_all();
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), '1, rand_line());
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
        idle();
    endtask

    initial begin
        m_busy = 1'b0; m_sweep = '0; m_valid = 1'b0; m_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        step(1'b1, 4'd1, '1, rand_line(), 1'b1, 4'd1, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        check("rst_rd_data", rd_data, '0);

        // Full-line write then read; then single-word masked update.
        wr(4'd5, 16'hFFFF, fill(16'd1, 16'd1));
        rd(4'd5);
        idle();
        wr(4'd5, 16'h0001, fill(16'hBEEF, 16'h0101));
        rd(4'd5);
        idle();

        // Same-address write-first read.
        wr(4'd7, 16'hFFFF, fill(16'h1111, 16'h0000));
        step(1'b1, 4'd7, 16'h00F0, fill(16'hAAAA, 16'h0000), 1'b1, 4'd7, 1'b0, 1'b0);
        idle();

        // Different addresses in the same cycle, then back-to-back reads.
        step(1'b1, 4'd3, 16'hA5C3, rand_line(), 1'b1, 4'd5, 1'b0, 1'b0);
        rd(4'd3);
        rd(4'd7);
        idle();

        // Clear sweep with traffic (and restart attempts) while busy.
        fill_all();
        read_all();
        busy_cnt = 0;
        step(1'b1, 4'd2, 16'hFFFF, rand_line(), 1'b1, 4'd9, 1'b1, 1'b0);
        for (int k = 0; k < 40 && m_busy; k++) begin
            step(1'b1, AW'($urandom), '1, rand_line(), 1'b1, AW'($urandom), 1'b1, 1'b0);
        end
        check("busy_cycles", LINE_W'(busy_cnt), LINE_W'(DEPTH));
        read_all();

        // Reset in the middle of a sweep.
        fill_all();
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 40 && m_sweep != AW'(6); k++) idle();
        step(1'b1, 4'd12, '1, rand_line(), 1'b1, 4'd12, 1'b1, 1'b1);
        idle();
        read_all();

        check("pending", LINE_W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/line_data_mem.md
LINE_DATA_MEM -- requirements
Module: line_data_mem

Interface
REQ-001 The block SHALL provide parameter WORD_W, default 16, width of one memory word in bits.
REQ-002 The block SHALL provide parameter WORDS, default 16, number of words per line.
REQ-003 The block SHALL provide parameter AW, default 12, line address width; depth is 2^AW lines.
REQ-004 The block SHALL derive LINE_W = WORD_W*WORDS as a local constant, not an overridable parameter.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  write request for one line.
REQ-008 wr_addr  input  AW  line address of write.
REQ-009 wr_mask  input  WORDS  per-word write enable; bit i gates word i.
REQ-010 wr_data  input  LINE_W  write line; word i at bits [i*WORD_W +: WORD_W].
REQ-011 rd_en  input  1  read request for one line.
REQ-012 rd_addr  input  AW  line address of read.
REQ-013 rd_data  output  LINE_W  registered read line; same word ordering as wr_data.
REQ-014 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-015 clr_start  input  1  request to zero-fill the whole memory.
REQ-016 busy  output  1  high while the clear sweep runs.

Function
REQ-017 Writes SHALL update only masked words of line wr_addr at the clock edge where wr_en=1 and busy=0; unmasked words keep their value.
REQ-018 A read accepted (rd_en=1, busy=0) in cycle N SHALL present rd_data and rd_valid=1 in cycle N+1; rd_valid SHALL be 0 in every other cycle.
REQ-019 rd_data SHALL hold its last value while rd_valid=0.
REQ-020 Read and write to the same address in the same cycle SHALL be write-first: rd_data returns masked words from wr_data, unmasked words from stored contents.
REQ-021 Read and write to different addresses in the same cycle SHALL both complete independently.
REQ-022 The controller SHALL have two states: IDLE and CLEAR.
REQ-023 IDLE -> CLEAR when clr_start=1; reads/writes in that same cycle are still serviced; busy rises the next cycle.
REQ-024 In CLEAR the block SHALL write all-zero to one line per cycle, addresses 0 to 2^AW-1 ascending, using an AW-bit sweep counter.
REQ-025 CLEAR -> IDLE after line 2^AW-1 is cleared; busy falls the following cycle; the clear lasts exactly 2^AW cycles.
REQ-026 While busy=1, wr_en and rd_en SHALL be ignored (no write, rd_valid stays 0), and clr_start SHALL be ignored.
REQ-027 The sweep counter SHALL not wrap: the terminal count is detected before increment.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, busy=0, rd_valid=0, rd_data=0, sweep counter=0.
REQ-029 Reset SHALL NOT alter memory contents; reset mid-clear leaves already-swept lines zero and the rest unchanged.
REQ-030 While rst=1, wr_en, rd_en and clr_start SHALL have no effect.

Structure
REQ-031 Package dm_pkg SHALL hold default WORD_W/WORDS/AW values and the IDLE/CLEAR state enumeration.
REQ-032 The clear controller (state, sweep counter, busy) SHALL be a sub-module named dm_clear_fsm; the storage array and read path stay in line_data_mem.
REQ-033 The block SHALL contain no file I/O; memory initialisation is by clr_start or writes only.

Verification
REQ-034 Write addr 5, mask 16'hFFFF, word i=i+1; read addr 5 next cycle -> rd_valid=1 one cycle later, word i=i+1.
REQ-035 Then write addr 5, mask 16'h0001, word0=16'hBEEF -> read returns word0=BEEF, words 1..15 unchanged.
REQ-036 Same-cycle write addr 7 mask 16'h00F0 data all-16'hAAAA plus read addr 7 (prior all 16'h1111) -> words 4..7=AAAA, others 1111.
REQ-037 AW=4: fill all lines nonzero, pulse clr_start -> busy high for exactly 16 cycles, rd_en during busy gives no rd_valid, afterwards every line reads 0.
REQ-038 AW=4: assert rst at sweep cycle 6 -> busy=0 next cycle, lines 0..5 read zero, lines 6..15 keep old data.
